// File: rtl/wshb_sdram_arbiter_pkg.sv
// ============================================================================
// Module   : wshb_arb_pkg
// Brief    : Shared types and Wishbone cycle-type codes for the SDRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_VGA = 2'd1,
        GNT_WR  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_VGA = 1'b0,
        REQ_WR  = 1'b1
    } req_id_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

`default_nettype wire

// File: rtl/wshb_if.sv
// ============================================================================
// Module   : wshb_if
// Brief    : Wishbone B4 bus bundle with master and slave modports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wshb_if #(
    parameter int DATA_BYTES = 4
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [31:0]             adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [DATA_BYTES-1:0]   sel;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, err, rty, dat_sm
    );
endinterface

`default_nettype wire

// File: rtl/wshb_sdram_arbiter_fsm.sv
// ============================================================================
// Module   : wshb_arb_fsm
// Brief    : Non-preemptive cyc-delimited grant FSM with saturating hold count.
//            WSHB_ARB_VGA_PRIO_EN selects fixed VGA priority over round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wshb_arb_fsm
    import wshb_arb_pkg::*;
#(
    parameter int HOLD_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vga_cyc,
    input  logic                  i_wr_cyc,
    output logic                  o_gnt_vga,
    output logic                  o_gnt_wr,
    output logic [HOLD_CNT_W-1:0] o_hold_cnt
);

    localparam logic [1:0] c_ST_IDLE    = IDLE;
    localparam logic [1:0] c_ST_GNT_VGA = GNT_VGA;
    localparam logic [1:0] c_ST_GNT_WR  = GNT_WR;
    localparam logic [HOLD_CNT_W-1:0] c_CNT_ONE = {{(HOLD_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic                  w_vga_turn;

    // vga_turn: on a tie, VGA takes the bus
    function automatic logic [1:0] f_pick(input logic vga, input logic wr, input logic vga_turn);
        if (vga && (!wr || vga_turn)) return c_ST_GNT_VGA;
        if (wr)                       return c_ST_GNT_WR;
        return c_ST_IDLE;
    endfunction

`ifdef WSHB_ARB_VGA_PRIO_EN
    assign w_vga_turn = 1'b1;
`else
    req_id_t r_last_srv;
    req_id_t w_last_nxt;

    assign w_vga_turn = (r_last_srv == REQ_WR);
`endif

    always_comb begin
        w_state_nxt = r_state;
`ifndef WSHB_ARB_VGA_PRIO_EN
        w_last_nxt  = r_last_srv;
`endif
        case (r_state)
            c_ST_IDLE:    w_state_nxt = f_pick(i_vga_cyc, i_wr_cyc, w_vga_turn);
            c_ST_GNT_VGA: if (!i_vga_cyc) begin
`ifndef WSHB_ARB_VGA_PRIO_EN
                w_last_nxt  = REQ_VGA;
`endif
                w_state_nxt = f_pick(i_vga_cyc, i_wr_cyc, 1'b0);
            end
            c_ST_GNT_WR:  if (!i_wr_cyc) begin
`ifndef WSHB_ARB_VGA_PRIO_EN
                w_last_nxt  = REQ_WR;
`endif
                w_state_nxt = f_pick(i_vga_cyc, i_wr_cyc, 1'b1);
            end
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_hold_cnt <= '0;
`ifndef WSHB_ARB_VGA_PRIO_EN
            r_last_srv <= REQ_WR;
`endif
        end else begin
            r_state <= w_state_nxt;
`ifndef WSHB_ARB_VGA_PRIO_EN
            r_last_srv <= w_last_nxt;
`endif
            if (w_state_nxt != r_state || r_state == c_ST_IDLE)
                r_hold_cnt <= '0;
            else if (r_hold_cnt != '1)
                r_hold_cnt <= r_hold_cnt + c_CNT_ONE;
        end
    end

    assign o_gnt_vga  = (r_state == c_ST_GNT_VGA);
    assign o_gnt_wr   = (r_state == c_ST_GNT_WR);
    assign o_hold_cnt = r_hold_cnt;

endmodule

`default_nettype wire

// File: rtl/wshb_sdram_arbiter.sv
// ============================================================================
// Module   : wshb_sdram_arbiter
// Brief    : Shares the SDRAM Wishbone slave between the VGA reader and the
//            framebuffer writer. WSHB_ARB_VGA_PRIO_EN selects fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wshb_sdram_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int HOLD_CNT_W = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    wshb_if.slave                 wshb_ifs_vga,
    wshb_if.slave                 wshb_ifs_wr,
    wshb_if.master                wshb_ifm,
    output logic                  gnt_vga,
    output logic                  gnt_wr,
    output logic [HOLD_CNT_W-1:0] hold_cnt
);

    logic [8*DATA_BYTES-1:0] w_dat_ms;
    logic [8*DATA_BYTES-1:0] w_dat_sm;

    wshb_arb_fsm #(
        .HOLD_CNT_W (HOLD_CNT_W)
    ) u_fsm (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .i_vga_cyc  (wshb_ifs_vga.cyc),
        .i_wr_cyc   (wshb_ifs_wr.cyc),
        .o_gnt_vga  (gnt_vga),
        .o_gnt_wr   (gnt_wr),
        .o_hold_cnt (hold_cnt)
    );

    // Forward path: selected purely by the registered grant, never by ack
    assign wshb_ifm.cyc = (gnt_vga & wshb_ifs_vga.cyc) | (gnt_wr & wshb_ifs_wr.cyc);
    assign wshb_ifm.stb = (gnt_vga & wshb_ifs_vga.stb) | (gnt_wr & wshb_ifs_wr.stb);
    assign wshb_ifm.we  = (gnt_vga & wshb_ifs_vga.we)  | (gnt_wr & wshb_ifs_wr.we);
    assign wshb_ifm.adr = gnt_vga ? wshb_ifs_vga.adr : (gnt_wr ? wshb_ifs_wr.adr : '0);
    assign wshb_ifm.sel = gnt_vga ? wshb_ifs_vga.sel : (gnt_wr ? wshb_ifs_wr.sel : '0);
    assign wshb_ifm.cti = gnt_vga ? wshb_ifs_vga.cti : (gnt_wr ? wshb_ifs_wr.cti : '0);
    assign wshb_ifm.bte = gnt_vga ? wshb_ifs_vga.bte : (gnt_wr ? wshb_ifs_wr.bte : '0);
    assign w_dat_ms     = gnt_vga ? wshb_ifs_vga.dat_ms : (gnt_wr ? wshb_ifs_wr.dat_ms : '0);
    assign wshb_ifm.dat_ms = w_dat_ms;

    // Return path: the non-granted master sees a silent slave and stalls
    assign w_dat_sm            = wshb_ifm.dat_sm;
    assign wshb_ifs_vga.ack    = gnt_vga & wshb_ifm.ack;
    assign wshb_ifs_vga.err    = gnt_vga & wshb_ifm.err;
    assign wshb_ifs_vga.rty    = gnt_vga & wshb_ifm.rty;
    assign wshb_ifs_vga.dat_sm = gnt_vga ? w_dat_sm : '0;
    assign wshb_ifs_wr.ack     = gnt_wr & wshb_ifm.ack;
    assign wshb_ifs_wr.err     = gnt_wr & wshb_ifm.err;
    assign wshb_ifs_wr.rty     = gnt_wr & wshb_ifm.rty;
    assign wshb_ifs_wr.dat_sm  = gnt_wr ? w_dat_sm : '0;

endmodule

`default_nettype wire

// File: tb/tb_wshb_sdram_arbiter.sv
// ============================================================================
// Module   : tb_wshb_sdram_arbiter
// Brief    : Directed vector bench for the two-master SDRAM Wishbone arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wshb_sdram_arbiter;
    import wshb_arb_pkg::*;

    localparam logic [31:0] c_VGA_ADR = 32'h0000_0100;
    localparam logic [31:0] c_WR_ADR  = 32'h0000_0200;
    localparam logic [31:0] c_SL_DAT  = 32'hCAFE_F00D;
    localparam logic [31:0] c_WR_DAT  = 32'h1234_5678;

    typedef struct {
        logic        rst, vcyc, wcyc, ack;
        logic        gv, gw;
        logic [15:0] hc;
        logic        mcyc;
        logic [31:0] madr;
        logic        vack, wack;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        gnt_vga, gnt_wr;
    logic [15:0] hold_cnt;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        vq[$];

    wshb_if #(.DATA_BYTES(4)) vga_if ();
    wshb_if #(.DATA_BYTES(4)) wr_if ();
    wshb_if #(.DATA_BYTES(4)) m_if ();

    wshb_sdram_arbiter #(.DATA_BYTES(4), .HOLD_CNT_W(16)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .wshb_ifs_vga (vga_if),
        .wshb_ifs_wr  (wr_if),
        .wshb_ifm     (m_if),
        .gnt_vga      (gnt_vga),
        .gnt_wr       (gnt_wr),
        .hold_cnt     (hold_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic ok, input string detail);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic add(input logic rst, vc, wc, ak, gv, gw, input int hc,
                       input logic mc, input logic [31:0] ma, input logic va, wa);
        vec_t v;
        v.rst = rst; v.vcyc = vc; v.wcyc = wc; v.ack = ak;
        v.gv = gv; v.gw = gw; v.hc = 16'(hc); v.mcyc = mc; v.madr = ma;
        v.vack = va; v.wack = wa;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rst, vc, wc, ak);
        sys_rst    = rst;
        vga_if.cyc = vc; vga_if.stb = vc;
        wr_if.cyc  = wc; wr_if.stb  = wc;
        m_if.ack   = ak;
    endtask

    initial begin
        logic [31:0] exp_vd, exp_wd;
        logic [2:0]  cti_b;

        vga_if.cyc = 0; vga_if.stb = 0; vga_if.we = 0; vga_if.adr = c_VGA_ADR;
        vga_if.dat_ms = '0; vga_if.sel = 4'hF; vga_if.cti = CTI_CLASSIC; vga_if.bte = 2'b00;
        wr_if.cyc = 0; wr_if.stb = 0; wr_if.we = 1; wr_if.adr = c_WR_ADR;
        wr_if.dat_ms = c_WR_DAT; wr_if.sel = 4'h3; wr_if.cti = CTI_CLASSIC; wr_if.bte = 2'b00;
        m_if.ack = 0; m_if.err = 0; m_if.rty = 0; m_if.dat_sm = c_SL_DAT;

        //   rst v w ack | gv gw hc mcyc madr       vack wack
        add(1, 0, 0, 0,   0, 0, 0, 0, 32'h0,     0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 0, 32'h0,     0, 0);
        add(0, 1, 0, 0,   1, 0, 0, 1, c_VGA_ADR, 0, 0);
        add(0, 1, 0, 0,   1, 0, 1, 1, c_VGA_ADR, 0, 0);
        add(0, 1, 0, 1,   1, 0, 2, 1, c_VGA_ADR, 1, 0);
        add(0, 0, 0, 0,   1, 0, 3, 0, c_VGA_ADR, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0, 32'h0,     0, 0);
        add(0, 1, 1, 1,   0, 0, 0, 0, 32'h0,     0, 0);
        add(0, 1, 1, 1,   0, 1, 0, 1, c_WR_ADR,  0, 1);
        add(0, 1, 0, 0,   0, 1, 1, 0, c_WR_ADR,  0, 0);
        add(0, 1, 1, 1,   1, 0, 0, 1, c_VGA_ADR, 1, 0);
        add(0, 0, 1, 0,   1, 0, 1, 0, c_VGA_ADR, 0, 0);
        add(0, 1, 1, 0,   0, 1, 0, 1, c_WR_ADR,  0, 0);
        add(1, 0, 1, 0,   0, 1, 1, 1, c_WR_ADR,  0, 0);
        add(0, 1, 1, 0,   0, 0, 0, 0, 32'h0,     0, 0);
        add(0, 1, 1, 0,   1, 0, 0, 1, c_VGA_ADR, 0, 0);
        add(0, 0, 0, 0,   1, 0, 1, 0, c_VGA_ADR, 0, 0);
        add(0, 0, 0, 0,   0, 0, 0, 0, 32'h0,     0, 0);

        repeat (2) @(posedge sys_clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge sys_clk);
            drive(vq[i].rst, vq[i].vcyc, vq[i].wcyc, vq[i].ack);
            #1;
            exp_vd = vq[i].gv ? c_SL_DAT : 32'h0;
            exp_wd = vq[i].gw ? c_SL_DAT : 32'h0;
            chk($sformatf("vec%0d", i),
                {gnt_vga, gnt_wr, hold_cnt, m_if.cyc, m_if.adr, vga_if.ack, wr_if.ack,
                 vga_if.dat_sm, wr_if.dat_sm} ===
                {vq[i].gv, vq[i].gw, vq[i].hc, vq[i].mcyc, vq[i].madr, vq[i].vack, vq[i].wack,
                 exp_vd, exp_wd},
                $sformatf("got gv=%b gw=%b hc=%0d mcyc=%b adr=%h vack=%b wack=%b vd=%h wd=%h, want gv=%b gw=%b hc=%0d mcyc=%b adr=%h vack=%b wack=%b vd=%h wd=%h",
                    gnt_vga, gnt_wr, hold_cnt, m_if.cyc, m_if.adr, vga_if.ack, wr_if.ack,
                    vga_if.dat_sm, wr_if.dat_sm, vq[i].gv, vq[i].gw, vq[i].hc, vq[i].mcyc,
                    vq[i].madr, vq[i].vack, vq[i].wack, exp_vd, exp_wd));
        end

        // VGA 16-beat incrementing burst with the writer waiting
        @(negedge sys_clk);
        vga_if.cti = CTI_INCR;
        drive(0, 1, 0, 0);
        @(negedge sys_clk);
        drive(0, 1, 1, 0);
        #1;
        chk("burst_start", gnt_vga === 1'b1 && gnt_wr === 1'b0 && hold_cnt === 16'd0,
            $sformatf("got gv=%b gw=%b hc=%0d, want gv=1 gw=0 hc=0", gnt_vga, gnt_wr, hold_cnt));
        for (int b = 0; b < 16; b++) begin
            @(negedge sys_clk);
            cti_b = (b == 15) ? CTI_EOB : CTI_INCR;
            vga_if.cti = cti_b;
            m_if.ack = 1;
            #1;
            chk($sformatf("burst_beat%0d", b),
                gnt_vga === 1'b1 && vga_if.ack === 1'b1 && wr_if.ack === 1'b0 &&
                m_if.cti === cti_b && m_if.we === 1'b0 && m_if.sel === 4'hF,
                $sformatf("got gv=%b vack=%b wack=%b cti=%b we=%b sel=%h, want 1 1 0 %b 0 f",
                    gnt_vga, vga_if.ack, wr_if.ack, m_if.cti, m_if.we, m_if.sel, cti_b));
        end
        @(negedge sys_clk);
        vga_if.cti = CTI_CLASSIC;
        drive(0, 0, 1, 0);
        #1;
        chk("burst_hold", gnt_vga === 1'b1 && gnt_wr === 1'b0 && hold_cnt === 16'd17,
            $sformatf("got gv=%b gw=%b hc=%0d, want gv=1 gw=0 hc=17", gnt_vga, gnt_wr, hold_cnt));

        // Handover to the writer, then slave err/rty on its access
        @(negedge sys_clk);
        m_if.err = 1; m_if.rty = 1;
        #1;
        chk("wr_err", gnt_wr === 1'b1 && gnt_vga === 1'b0 && hold_cnt === 16'd0 &&
            wr_if.err === 1'b1 && wr_if.rty === 1'b1 && vga_if.err === 1'b0 &&
            vga_if.rty === 1'b0 && m_if.we === 1'b1 && m_if.dat_ms === c_WR_DAT &&
            m_if.sel === 4'h3,
            $sformatf("got gw=%b gv=%b hc=%0d werr=%b wrty=%b verr=%b vrty=%b we=%b dat=%h sel=%h",
                gnt_wr, gnt_vga, hold_cnt, wr_if.err, wr_if.rty, vga_if.err, vga_if.rty,
                m_if.we, m_if.dat_ms, m_if.sel));
        @(negedge sys_clk);
        m_if.err = 0; m_if.rty = 0;
        #1;
        chk("wr_err_hold", gnt_wr === 1'b1 && hold_cnt === 16'd1 && wr_if.err === 1'b0,
            $sformatf("got gw=%b hc=%0d werr=%b, want gw=1 hc=1 werr=0", gnt_wr, hold_cnt, wr_if.err));
        @(negedge sys_clk);
        drive(0, 0, 0, 0);
        @(negedge sys_clk);
        #1;
        chk("final_idle", gnt_wr === 1'b0 && gnt_vga === 1'b0 && hold_cnt === 16'd0 &&
            m_if.cyc === 1'b0 && m_if.adr === 32'h0,
            $sformatf("got gv=%b gw=%b hc=%0d mcyc=%b adr=%h, want all zero",
                gnt_vga, gnt_wr, hold_cnt, m_if.cyc, m_if.adr));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
